// File: rtl/multi_input_adder_tree.sv
// Pipelined signed adder tree: sums NUM_INPUT samples per beat through
// max(1, clog2(NUM_INPUT)) register levels, with a valid tag, clock enable,
// asynchronous reset and optional saturating or wrapping output narrowing.
module multi_input_adder_tree #(
    parameter int NUM_INPUT     = 2,
    parameter int DATA_WIDTH_IN = 16,
    parameter int OUT_WIDTH     = 0,
    parameter int SATURATE      = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ena,
    input  logic                            din_valid,
    input  logic signed [DATA_WIDTH_IN-1:0] din [NUM_INPUT],
    output logic                            dout_valid,
    output logic signed [((OUT_WIDTH == 0) ? (DATA_WIDTH_IN + $clog2(NUM_INPUT)) : OUT_WIDTH)-1:0] dout,
    output logic                            ovf
);

    localparam int FULL_W = DATA_WIDTH_IN + $clog2(NUM_INPUT);
    localparam int OW     = (OUT_WIDTH == 0) ? FULL_W : OUT_WIDTH;
    localparam int LEVELS = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;

    // Number of partial sums held at tree level k (level 0 is din).
    function automatic int lvl_cnt(input int k);
        return (NUM_INPUT + (1 << k) - 1) >> k;
    endfunction

    // Narrow the full-precision sum to OW bits. Overflow means the bits above
    // the OW-bit sign position are not a pure sign extension; in saturating
    // mode the result is then clamped to the limit matching the sum's sign.
    function automatic logic [OW:0] narrow_sum(input logic signed [FULL_W-1:0] s);
        logic [FULL_W-OW:0] top;
        logic [OW-1:0]      res;
        logic [OW-1:0]      lim;
        logic               o;
        top = s[FULL_W-1:OW-1];
        o   = ~((&top) | ~(|top));
        res = s[OW-1:0];
        lim = '0;
        if ((SATURATE != 0) && o) begin
            lim[OW-1] = 1'b1;
            if (!s[FULL_W-1]) begin
                lim = ~lim;
            end
            res = lim;
        end
        return {o, res};
    endfunction

    // Every level is viewed sign-extended to FULL_W so the next level can pick
    // its operands uniformly; each level's registers keep only its own width.
    logic signed [FULL_W-1:0] view [LEVELS][NUM_INPUT];

    genvar k, j;

    for (j = 0; j < NUM_INPUT; j++) begin : g_in
        assign view[0][j] = FULL_W'(din[j]);
    end

    for (k = 1; k < LEVELS; k++) begin : g_lvl
        localparam int CNT  = lvl_cnt(k);
        localparam int PCNT = lvl_cnt(k - 1);
        localparam int LW   = DATA_WIDTH_IN + k;

        logic signed [LW-1:0] sum_d [CNT];
        logic signed [LW-1:0] sum_q [CNT];

        for (j = 0; j < CNT; j++) begin : g_node
            if (2 * j + 1 < PCNT) begin : g_add
                assign sum_d[j] = LW'(view[k-1][2*j]) + LW'(view[k-1][2*j+1]);
            end else begin : g_pass
                // Odd element count: the last element is carried forward alone.
                assign sum_d[j] = LW'(view[k-1][2*j]);
            end
            assign view[k][j] = FULL_W'(sum_q[j]);
        end

        for (j = CNT; j < NUM_INPUT; j++) begin : g_unused
            assign view[k][j] = '0;
        end

        // Partial-sum register for this tree level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < CNT; i++) sum_q[i] <= '0;
            end else if (ena) begin
                for (int i = 0; i < CNT; i++) sum_q[i] <= sum_d[i];
            end
        end
    end

    // Final stage: the last level holds at most two operands.
    logic signed [FULL_W-1:0] full_sum;
    if (lvl_cnt(LEVELS - 1) > 1) begin : g_final_add
        assign full_sum = view[LEVELS-1][0] + view[LEVELS-1][1];
    end else begin : g_final_pass
        assign full_sum = view[LEVELS-1][0];
    end

    logic [OW:0]          narrow_d;
    logic signed [OW-1:0] dout_q;
    logic                 ovf_q;
    logic [LEVELS-1:0]    vld_q;

    assign narrow_d = narrow_sum(full_sum);

    // Output register: narrowed sum and its overflow flag load together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            ovf_q  <= 1'b0;
        end else if (ena) begin
            dout_q <= narrow_d[OW-1:0];
            ovf_q  <= narrow_d[OW];
        end
    end

    // Valid shift register, one bit per tree level, moving with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (ena) begin
            vld_q[0] <= din_valid;
            for (int i = 1; i < LEVELS; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    assign dout       = dout_q;
    assign ovf        = ovf_q;
    assign dout_valid = vld_q[LEVELS-1];

endmodule

// File: tb/tb_multi_input_adder_tree.sv
// Bench for multi_input_adder_tree: six configurations side by side, a
// queue-based sum/narrowing model checked every cycle, plus literal pins.
module tb_multi_input_adder_tree;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    always #5 clk = ~clk;

    // Stimulus groups: N=5/W=8 (A,B,C), N=8/W=4 (D), N=1/W=8 (E), N=3/W=8 (F)
    logic signed [7:0] din5 [5];
    logic signed [3:0] din8 [8];
    logic signed [7:0] din1 [1];
    logic signed [7:0] din3 [3];
    logic v5, v8, v1, v3;

    logic signed [10:0] dout_a;
    logic signed [7:0]  dout_b, dout_c, dout_e;
    logic signed [6:0]  dout_d;
    logic signed [9:0]  dout_f;
    logic val_a, val_b, val_c, val_d, val_e, val_f;
    logic ovf_a, ovf_b, ovf_c, ovf_d, ovf_e, ovf_f;

    multi_input_adder_tree #(.NUM_INPUT(5), .DATA_WIDTH_IN(8), .OUT_WIDTH(0), .SATURATE(1)) u_a (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(v5), .din(din5),
        .dout_valid(val_a), .dout(dout_a), .ovf(ovf_a));
    multi_input_adder_tree #(.NUM_INPUT(5), .DATA_WIDTH_IN(8), .OUT_WIDTH(8), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(v5), .din(din5),
        .dout_valid(val_b), .dout(dout_b), .ovf(ovf_b));
    multi_input_adder_tree #(.NUM_INPUT(5), .DATA_WIDTH_IN(8), .OUT_WIDTH(8), .SATURATE(0)) u_c (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(v5), .din(din5),
        .dout_valid(val_c), .dout(dout_c), .ovf(ovf_c));
    multi_input_adder_tree #(.NUM_INPUT(8), .DATA_WIDTH_IN(4), .OUT_WIDTH(0), .SATURATE(1)) u_d (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(v8), .din(din8),
        .dout_valid(val_d), .dout(dout_d), .ovf(ovf_d));
    multi_input_adder_tree #(.NUM_INPUT(1), .DATA_WIDTH_IN(8), .OUT_WIDTH(0), .SATURATE(1)) u_e (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(v1), .din(din1),
        .dout_valid(val_e), .dout(dout_e), .ovf(ovf_e));
    multi_input_adder_tree #(.NUM_INPUT(3), .DATA_WIDTH_IN(8), .OUT_WIDTH(0), .SATURATE(1)) u_f (
        .clk(clk), .rst(rst), .ena(ena), .din_valid(v3), .din(din3),
        .dout_valid(val_f), .dout(dout_f), .ovf(ovf_f));

    // Per-instance latency (tree depth), output width and narrowing mode
    localparam int LV   [6] = '{3, 3, 3, 3, 1, 2};
    localparam int OWV  [6] = '{11, 8, 8, 7, 8, 10};
    localparam int SATV [6] = '{1, 1, 0, 1, 1, 1};

    logic signed [63:0] act_d [6];
    logic               act_v [6];
    logic               act_o [6];
    assign act_d[0] = 64'(dout_a); assign act_v[0] = val_a; assign act_o[0] = ovf_a;
    assign act_d[1] = 64'(dout_b); assign act_v[1] = val_b; assign act_o[1] = ovf_b;
    assign act_d[2] = 64'(dout_c); assign act_v[2] = val_c; assign act_o[2] = ovf_c;
    assign act_d[3] = 64'(dout_d); assign act_v[3] = val_d; assign act_o[3] = ovf_d;
    assign act_d[4] = 64'(dout_e); assign act_v[4] = val_e; assign act_o[4] = ovf_e;
    assign act_d[5] = 64'(dout_f); assign act_v[5] = val_f; assign act_o[5] = ovf_f;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out [6] = '{0, 0, 0, 0, 0, 0};

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Output narrowing from the plain arithmetic definition
    function automatic void narrow(input int ow, input int sat, input longint s,
                                   output longint d, output bit o);
        longint hi, lo, m, span;
        span = longint'(1) <<< ow;
        hi   = (longint'(1) <<< (ow - 1)) - 1;
        lo   = -hi - 1;
        if (sat != 0) begin
            if (s > hi)      begin d = hi; o = 1'b1; end
            else if (s < lo) begin d = lo; o = 1'b1; end
            else             begin d = s;  o = 1'b0; end
        end else begin
            m = s & (span - 1);
            if (m > hi) m = m - span;
            d = m;
            o = (m != s);
        end
    endfunction

    typedef struct {
        int     inst;
        int     due;
        longint d;
        bit     o;
        bit     seen;
    } ent_t;
    ent_t q[$];
    int   en_cnt = 0;

    task automatic push(input int i, input longint s);
        ent_t e;
        e.inst = i;
        e.due  = en_cnt + LV[i] - 1;
        narrow(OWV[i], SATV[i], s, e.d, e.o);
        e.seen = 1'b0;
        q.push_back(e);
    endtask

    // Model: each enabled edge accepts a beat; it is due LV-1 enabled edges later
    always @(posedge clk) begin
        longint s5, s8, s1, s3;
        if (!rst && ena) begin
            en_cnt++;
            s5 = 0; s8 = 0; s3 = 0;
            for (int j = 0; j < 5; j++) s5 += longint'(din5[j]);
            for (int j = 0; j < 8; j++) s8 += longint'(din8[j]);
            for (int j = 0; j < 3; j++) s3 += longint'(din3[j]);
            s1 = longint'(din1[0]);
            if (v5) begin push(0, s5); push(1, s5); push(2, s5); end
            if (v8) push(3, s8);
            if (v1) push(4, s1);
            if (v3) push(5, s3);
        end
    end

    always @(posedge rst) q.delete();

    // Compare: valid must match the model every cycle; data/ovf when valid
    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            bit found;
            int fk;
            found = 1'b0;
            fk    = 0;
            for (int k = 0; k < q.size(); k++)
                if (q[k].inst == i && q[k].due == en_cnt) begin found = 1'b1; fk = k; end
            if (found) begin
                chk($sformatf("valid[%0d]", i), 64'(act_v[i]), 1);
                chk($sformatf("dout[%0d]", i), act_d[i], q[fk].d);
                chk($sformatf("ovf[%0d]", i), 64'(act_o[i]), 64'(q[fk].o));
                if (act_v[i] === 1'b1 && !q[fk].seen) begin
                    q[fk].seen = 1'b1;
                    n_out[i]++;
                end
            end else begin
                chk($sformatf("idle_valid[%0d]", i), 64'(act_v[i]), 0);
            end
        end
        for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].due < en_cnt) q.delete(k);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    bit pat [7] = '{1, 1, 0, 0, 1, 0, 1};

    initial begin
        int sent;
        rst = 1'b1; ena = 1'b1;
        v5 = 1'b0; v8 = 1'b0; v1 = 1'b0; v3 = 1'b0;
        din5 = '{5{8'sd0}}; din8 = '{8{4'sd0}}; din1 = '{8'sd0}; din3 = '{3{8'sd0}};
        repeat (3) tick();
        chk("rst_dout_a", act_d[0], 0);
        chk("rst_valid_a", 64'(val_a), 0);
        chk("rst_ovf_b", 64'(ovf_b), 0);
        chk("rst_dout_d", act_d[3], 0);
        chk("rst_valid_f", 64'(val_f), 0);
        rst = 1'b0;
        tick();

        // Three back-to-back beats on the N=5 group
        din5 = '{8'sd10, -8'sd3, 8'sd0, 8'sd5, 8'sd1}; v5 = 1'b1;
        tick();
        din5 = '{5{-8'sd128}};
        tick();
        chk("a_not_yet", 64'(val_a), 0);
        din5 = '{5{8'sd127}};
        tick();
        v5 = 1'b0;
        chk("a_small_valid", 64'(val_a), 1);
        chk("a_small", act_d[0], 13);
        chk("b_small", act_d[1], 13);
        chk("b_small_ovf", 64'(ovf_b), 0);
        chk("c_small", act_d[2], 13);
        tick();
        chk("a_neg", act_d[0], -640);
        chk("b_neg_sat", act_d[1], -128);
        chk("b_neg_ovf", 64'(ovf_b), 1);
        chk("c_neg_wrap", act_d[2], -128);
        chk("c_neg_ovf", 64'(ovf_c), 1);
        tick();
        chk("a_pos", act_d[0], 635);
        chk("a_pos_ovf", 64'(ovf_a), 0);
        chk("b_pos_sat", act_d[1], 127);
        chk("b_pos_ovf", 64'(ovf_b), 1);
        chk("c_pos_wrap", act_d[2], 123);
        chk("c_pos_ovf", 64'(ovf_c), 1);
        tick();
        chk("a_one_cycle", 64'(val_a), 0);

        // N=1 single register and N=3 odd pass-through
        din1 = '{-8'sd77}; v1 = 1'b1;
        din3 = '{3{-8'sd128}}; v3 = 1'b1;
        tick();
        v1 = 1'b0; v3 = 1'b0;
        chk("e_valid", 64'(val_e), 1);
        chk("e_dout", act_d[4], -77);
        tick();
        chk("f_valid", 64'(val_f), 1);
        chk("f_dout", act_d[5], -384);
        chk("f_ovf", 64'(ovf_f), 0);
        chk("e_one_cycle", 64'(val_e), 0);

        // 20 beats on N=8 under an irregular enable pattern
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            ena = pat[c % 7];
            if (ena && sent < 20) begin
                for (int j = 0; j < 8; j++) din8[j] = 4'($urandom_range(0, 15));
                v8 = 1'b1;
                sent++;
            end else if (ena) begin
                v8 = 1'b0;
            end
            tick();
        end
        ena = 1'b1; v8 = 1'b0;
        tick();
        chk("d_beats_delivered", 64'(n_out[3]), 20);

        // Reset between edges with two beats in flight
        din8 = '{8{4'sd5}}; v8 = 1'b1;
        tick();
        din8 = '{8{-4'sd3}};
        tick();
        v8 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid_d", 64'(val_d), 0);
        chk("mid_rst_dout_d", act_d[3], 0);
        chk("mid_rst_dout_b", act_d[1], 0);
        chk("mid_rst_ovf_b", 64'(ovf_b), 0);
        chk("mid_rst_ovf_c", 64'(ovf_c), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        din8 = '{4'sd7, -4'sd8, 4'sd3, 4'sd3, 4'sd1, -4'sd1, 4'sd0, 4'sd2}; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        tick();
        chk("post_rst_not_yet", 64'(val_d), 0);
        tick();
        chk("post_rst_valid", 64'(val_d), 1);
        chk("post_rst_dout", act_d[3], 7);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_input_adder_tree.md
# multi_input_adder_tree

Pipelined, parametrised signed adder tree that sums `NUM_INPUT` samples per valid beat. It is the successor to the single-cycle multi-input adder. It adds:

- one register level per tree stage, for timing closure at large `NUM_INPUT`;
- valid tagging;
- clock-enable stall;
- asynchronous reset;
- a configurable output width with saturate or wrap narrowing and an overflow flag.

It sits in DSP datapaths (FIR tap summation, channel combining, accumulators) between multiplier banks and downstream fixed-point stages.

## Interface
- `NUM_INPUT`, 2, number of signed inputs summed per beat (≥1).
- `DATA_WIDTH_IN`, 16, width of each signed input (≥1).
- `OUT_WIDTH`, 0, output width. 0 selects full precision `FULL_W = DATA_WIDTH_IN + $clog2(NUM_INPUT)`. Legal range 1..`FULL_W`.
- `SATURATE`, 1, narrowing mode when `OUT_WIDTH < FULL_W`: 1 clamps to the signed range, 0 drops MSBs (wraps).
- Ports:
  - `clk` in 1: rising-edge clock. This is the only clock.
  - `rst` in 1: reset, asynchronous, active-high.
  - `ena` in 1: clock enable for every register in the block.
  - `din_valid` in 1: `din` carries a beat to be summed.
  - `din` in `NUM_INPUT` × `DATA_WIDTH_IN`: unpacked array of signed samples.
  - `dout_valid` out 1: `dout` and `ovf` hold a finished sum.
  - `dout` out `OW`: signed sum, narrowed per `SATURATE`. `OW` = `OUT_WIDTH`, or `FULL_W` when `OUT_WIDTH` = 0.
  - `ovf` out 1: the full-precision sum did not fit in `OW` bits.

## Operation
- Tree depth: `LEVELS = max(1, $clog2(NUM_INPUT))`.
- Level k (1..`LEVELS`) holds `ceil(NUM_INPUT/2^k)` partial sums, each `DATA_WIDTH_IN + k` bits signed.
  - Element j of level k is element 2j plus element 2j+1 of level k−1, both sign-extended.
  - When level k−1 has an odd count, its last element passes through sign-extended, unregistered-add but still registered.
  - Level 0 is `din`.
- Every level, including the final one, is a register. No combinational path runs from `din` to `dout`.
- Final stage:
  - Computes the full sum S (`FULL_W` bits), narrows it to `OW` bits and registers `dout` and `ovf` in the same register.
  - Full precision (`OW == FULL_W`): `dout = S`, `ovf = 0` always.
  - `SATURATE = 1`:
    - S > 2^(OW−1)−1 gives `dout = 2^(OW−1)−1`, `ovf = 1`.
    - S < −2^(OW−1) gives `dout = −2^(OW−1)`, `ovf = 1`.
    - Otherwise `dout = S`, `ovf = 0`.
  - `SATURATE = 0`: `dout = S[OW−1:0]`. `ovf = 1` iff S differs from the sign-extension of `dout`.
- Valid pipeline: a `LEVELS`-deep shift register carries `din_valid` alongside the data.
  - Data registers load every enabled cycle, regardless of valid. Gating data on valid is not required.
  - Downstream consumers must qualify `dout` with `dout_valid`.
- `ena = 0`: every data and valid register holds. The pipeline freezes with no beat lost or duplicated. `dout`, `dout_valid` and `ovf` stay stable.
- `NUM_INPUT = 1`: `LEVELS = 1` and `dout` is `din[0]` registered, with narrowing applied.
- No back-pressure. The consumer must accept every `dout_valid` beat, or throttle the whole block with `ena`.

## Timing
- Latency is exactly `LEVELS` enabled cycles from `din_valid` sampled high to the matching `dout_valid` high.
- Throughput is one beat per enabled cycle. Back-to-back beats produce back-to-back outputs.
- Reset:
  - Asserting `rst` clears, immediately and without waiting for `clk`: all partial sums, `dout = 0`, `dout_valid = 0`, `ovf = 0`.
  - Beats in flight are discarded.
  - After `rst` deasserts, the first `din_valid` is sampled on the next rising edge.
- Reset overrides `ena`.
- Disabled cycles do not count toward latency.

## Test plan
- N=5, W=8, OUT_WIDTH=0 (`LEVELS` = 3, `FULL_W` = 11), single beat with `din` = {127,127,127,127,127} -> `dout` = 635, `ovf` = 0, `dout_valid` high exactly 3 cycles later and for 1 cycle.
- N=5, W=8, OUT_WIDTH=8, SATURATE=1: all inputs 127 -> `dout` = 127, `ovf` = 1. All inputs −128 -> `dout` = −128, `ovf` = 1. Inputs {10,−3,0,5,1} -> `dout` = 13, `ovf` = 0.
- Same beats with SATURATE=0 -> `dout` = 123 (635 mod 256), `ovf` = 1. All −128 (S = −640) -> `dout` = −128, `ovf` = 1. {10,−3,0,5,1} -> `dout` = 13, `ovf` = 0.
- N=8, W=4: 20 back-to-back random beats with an `ena` pattern 1,1,0,0,1,0,1… -> outputs match the golden sums in order, no drops or duplicates, and each latency equals 3 enabled cycles.
- Reset mid-stream (N=8, two beats in flight): pulse `rst` between clock edges -> `dout_valid`, `dout` and `ovf` go to 0 before the next edge, and no stale beat ever appears. A beat issued after release emerges 3 cycles later, correct.
- N=1, W=8, OUT_WIDTH=0: `din[0]` = −77 -> `dout` = −77 after 1 cycle. N=3, W=8: {−128,−128,−128} -> `dout` = −384, `ovf` = 0 (odd pass-through path).
